// File: rtl/adc_manager_pkg.sv
//------------------------------------------------------------------------------
// Module      : adc_manager_pkg
// Description : Shared types and constants for the multi-lane SPI SAR ADC
//               controller (FSM state encoding, command width, GAP length,
//               status word bit positions).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package adc_manager_pkg;

   // Controller states; the encoding is exported in status[1:0]
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_GAP   = 2'd3
   } adc_state_t;

   // Bits of a register command shifted out on spi_sdo
   localparam int c_cmd_width = 24;

   // aclk cycles spi_csn stays high between transfers
   localparam int c_gap_len = 2;

   // Width of the SCK period counter
   localparam int c_sck_cnt_w = 8;

   // Status word layout
   localparam int c_stat_state_lsb = 0;
   localparam int c_stat_tvalid    = 2;
   localparam int c_stat_overflow  = 3;
   localparam int c_stat_missed    = 4;
   localparam int c_stat_count_lsb = 16;

endpackage

`default_nettype wire

// File: rtl/adc_manager_sck_gen.sv
//------------------------------------------------------------------------------
// Module      : adc_sck_gen
// Description : SPI mode-0 clock generator. A start pulse loads the number of
//               SCK periods; SCK then toggles every clk cycle (clk/2) starting
//               low. Provides strobes for the edge about to be produced and a
//               one-cycle done pulse after the last falling edge.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module adc_sck_gen
   import adc_manager_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_start,
   input  logic [c_sck_cnt_w-1:0] i_load,
   output logic                   o_sck,
   output logic                   o_sck_rise,
   output logic                   o_sck_fall,
   output logic                   o_done
);

   logic                   r_active;
   logic                   r_sck;
   logic                   r_done;
   logic [c_sck_cnt_w-1:0] r_cnt;
   logic                   w_last;

   // Strobes describe the SCK edge the next clk edge will produce
   assign o_sck_rise = r_active & ~r_sck;
   assign o_sck_fall = r_active &  r_sck;
   assign w_last     = o_sck_fall && (r_cnt == c_sck_cnt_w'(1));

   // Toggle SCK while active, counting completed periods on falling edges
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_active <= 1'b0;
         r_sck    <= 1'b0;
         r_done   <= 1'b0;
         r_cnt    <= '0;
      end else if (i_start) begin
         r_active <= 1'b1;
         r_sck    <= 1'b0;
         r_done   <= 1'b0;
         r_cnt    <= i_load;
      end else begin
         r_done <= w_last;
         if (r_active) begin
            r_sck <= ~r_sck;
            if (o_sck_fall) begin
               r_cnt <= r_cnt - c_sck_cnt_w'(1);
            end
            if (w_last) begin
               r_active <= 1'b0;
            end
         end
      end
   end

   assign o_sck  = r_sck;
   assign o_done = r_done;

endmodule

`default_nettype wire

// File: rtl/adc_manager.sv
//------------------------------------------------------------------------------
// Module      : adc_manager
// Description : Multi-lane SPI SAR ADC controller. Forwards 24-bit register
//               commands from an AXI-Stream slave to the ADC and, on each
//               conversion-done trigger, reads one DATA_WIDTH-bit sample over
//               NUM_SDI lanes and presents it on an AXI-Stream master.
//               Optional feature macro: ADC_MANAGER_CNV_COUNTER_EN adds a
//               16-bit completed-read counter in status[31:16].
//               The aresetn port is an asynchronous ACTIVE-HIGH reset.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module adc_manager
   import adc_manager_pkg::*;
#(
   parameter int NUM_SDI    = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [NUM_SDI-1:0]    spi_sdi,
   output logic                  spi_sdo,
   output logic                  spi_csn,
   output logic                  spi_clk,
   output logic                  spi_resetn,
   input  logic                  trigger,
   input  logic [31:0]           s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [31:0]           status,
   output logic                  ready
);

   localparam logic [c_sck_cnt_w-1:0] c_load_cmd = c_sck_cnt_w'(c_cmd_width);
   localparam logic [c_sck_cnt_w-1:0] c_load_rd  = c_sck_cnt_w'(DATA_WIDTH / NUM_SDI);
   localparam logic [1:0]             c_gap_init = 2'(c_gap_len - 1);

   adc_state_t              r_state;
   adc_state_t              w_state_next;
   logic                    r_run;
   logic [2:0]              r_trig_sync;
   logic                    w_trig_edge;
   logic                    w_s_tready;
   logic                    w_cmd_fire;
   logic                    w_sck_start;
   logic [c_sck_cnt_w-1:0]  w_sck_load;
   logic                    w_sck_rise;
   logic                    w_sck_fall;
   logic                    w_sck_done;
   logic                    w_xfer;
   logic                    w_rd_done;
   logic                    r_fin;
   logic                    r_csn;
   logic [1:0]              r_gap_cnt;
   logic [c_cmd_width-1:0]  r_cmd;
   logic [DATA_WIDTH-1:0]   r_shift;
   logic [DATA_WIDTH-1:0]   r_mdata;
   logic                    r_mvalid;
   logic                    r_overflow;
   logic                    r_missed;
   logic [NUM_SDI-1:0]      w_sdi_group;
   logic [15:0]             w_cnv_count;
   logic                    w_unused_tdata;

   // Upper command byte carries no information for the ADC
   assign w_unused_tdata = ^s_axis_tdata[31:c_cmd_width];

   // Lane 0 is the most significant bit of each shifted-in group
   for (genvar gi = 0; gi < NUM_SDI; gi++) begin : g_lane
      assign w_sdi_group[NUM_SDI-1-gi] = spi_sdi[gi];
   end

   // Keep handshakes closed until the first clock after reset release
   always_ff @(posedge aclk or posedge aresetn) begin
      if (aresetn) r_run <= 1'b0;
      else         r_run <= 1'b1;
   end

   // Two-flop synchronizer plus a history flop for rising-edge detection
   always_ff @(posedge aclk or posedge aresetn) begin
      if (aresetn) r_trig_sync <= '0;
      else         r_trig_sync <= {r_trig_sync[1:0], trigger};
   end

   assign w_trig_edge = r_trig_sync[1] & ~r_trig_sync[2];
   assign w_xfer      = (r_state == ST_WRITE) || (r_state == ST_READ);
   assign w_rd_done   = (r_state == ST_READ) && w_sck_done;
   // A simultaneous trigger wins, so the command is refused that cycle
   assign w_s_tready  = r_run && (r_state == ST_IDLE) && !w_trig_edge;

   // State register
   always_ff @(posedge aclk or posedge aresetn) begin
      if (aresetn) r_state <= ST_IDLE;
      else         r_state <= w_state_next;
   end

   // Next-state logic and transfer start strobes
   always_comb begin
      w_state_next = r_state;
      w_cmd_fire   = 1'b0;
      w_sck_start  = 1'b0;
      w_sck_load   = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_trig_edge) begin
               w_state_next = ST_READ;
               w_sck_start  = 1'b1;
               w_sck_load   = c_load_rd;
            end else if (s_axis_tvalid && w_s_tready) begin
               w_state_next = ST_WRITE;
               w_cmd_fire   = 1'b1;
               w_sck_start  = 1'b1;
               w_sck_load   = c_load_cmd;
            end
         end
         ST_WRITE, ST_READ: begin
            if (r_fin) w_state_next = ST_GAP;
         end
         ST_GAP: begin
            if (r_gap_cnt == 2'd0) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   adc_sck_gen u_sck_gen (
      .clk        (aclk),
      .rst        (aresetn),
      .i_start    (w_sck_start),
      .i_load     (w_sck_load),
      .o_sck      (spi_clk),
      .o_sck_rise (w_sck_rise),
      .o_sck_fall (w_sck_fall),
      .o_done     (w_sck_done)
   );

   // Chip select low from transfer start until the cycle after the last SCK fall
   always_ff @(posedge aclk or posedge aresetn) begin
      if (aresetn) begin
         r_csn <= 1'b1;
         r_fin <= 1'b0;
      end else begin
         r_fin <= w_xfer && w_sck_done;
         if (w_sck_start)               r_csn <= 1'b0;
         else if (w_xfer && w_sck_done) r_csn <= 1'b1;
      end
   end

   // GAP dwell counter, loaded as the transfer's final cycle ends
   always_ff @(posedge aclk or posedge aresetn) begin
      if (aresetn)                                    r_gap_cnt <= '0;
      else if (w_xfer && r_fin)                       r_gap_cnt <= c_gap_init;
      else if (r_state == ST_GAP && r_gap_cnt != 2'd0) r_gap_cnt <= r_gap_cnt - 2'd1;
   end

   // Command shifter: bit 23 shown with csn fall, next bit on each SCK fall
   always_ff @(posedge aclk or posedge aresetn) begin
      if (aresetn)                                r_cmd <= '0;
      else if (w_cmd_fire)                        r_cmd <= s_axis_tdata[c_cmd_width-1:0];
      else if (r_state == ST_WRITE && w_sck_fall) r_cmd <= {r_cmd[c_cmd_width-2:0], 1'b0};
   end

   // Sample lanes on the edge that raises SCK, before the ADC updates them
   always_ff @(posedge aclk or posedge aresetn) begin
      if (aresetn)                               r_shift <= '0;
      else if (r_state == ST_READ && w_sck_rise) r_shift <= {r_shift[DATA_WIDTH-NUM_SDI-1:0], w_sdi_group};
   end

   // Output sample register; a completed read overwrites any pending sample
   always_ff @(posedge aclk or posedge aresetn) begin
      if (aresetn) begin
         r_mdata    <= '0;
         r_mvalid   <= 1'b0;
         r_overflow <= 1'b0;
      end else if (w_rd_done) begin
         r_mdata  <= r_shift;
         r_mvalid <= 1'b1;
         if (r_mvalid && !m_axis_tready) r_overflow <= 1'b1;
      end else if (r_mvalid && m_axis_tready) begin
         r_mvalid <= 1'b0;
      end
   end

   // Sticky flag for trigger edges that arrive while busy
   always_ff @(posedge aclk or posedge aresetn) begin
      if (aresetn)                                r_missed <= 1'b0;
      else if (w_trig_edge && r_state != ST_IDLE) r_missed <= 1'b1;
   end

`ifdef ADC_MANAGER_CNV_COUNTER_EN
   logic [15:0] r_cnv_count;

   // Wrapping count of completed reads
   always_ff @(posedge aclk or posedge aresetn) begin
      if (aresetn)        r_cnv_count <= '0;
      else if (w_rd_done) r_cnv_count <= r_cnv_count + 16'd1;
   end

   assign w_cnv_count = r_cnv_count;
`else
   assign w_cnv_count = 16'h0000;
`endif

   assign spi_sdo       = r_cmd[c_cmd_width-1];
   assign spi_csn       = r_csn;
   assign spi_resetn    = r_run;
   assign s_axis_tready = w_s_tready;
   assign m_axis_tdata  = r_mdata;
   assign m_axis_tvalid = r_mvalid;
   assign ready         = r_run && (r_state == ST_IDLE);
   assign status        = {w_cnv_count, 11'b0, r_missed, r_overflow, r_mvalid, r_state};

endmodule

`default_nettype wire

// File: tb/tb_adc_manager.sv
//------------------------------------------------------------------------------
// Module      : tb_adc_manager
// Description : Directed self-checking bench for adc_manager with a simple
//               ADC model (command capture on SCK rise, 4-lane sample output
//               updated after SCK rise).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_adc_manager;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b1;
   logic [3:0]  spi_sdi = 4'h0;
   logic        spi_sdo, spi_csn, spi_clk, spi_resetn;
   logic        trigger = 1'b0;
   logic [31:0] s_axis_tdata = 32'h0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b0;
   logic [31:0] status;
   logic        ready;

   int total = 0;
   int bad = 0;
   int reads_done = 0;

   // ADC model state
   logic [31:0] adc_pattern = 32'h0;
   logic [31:0] model_shift = 32'h0;
   logic [23:0] model_cmd = 24'h0;
   int          model_rises = 0;
   int          last_rises = 0;

   adc_manager #(.NUM_SDI(4), .DATA_WIDTH(32)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .spi_sdi       (spi_sdi),
      .spi_sdo       (spi_sdo),
      .spi_csn       (spi_csn),
      .spi_clk       (spi_clk),
      .spi_resetn    (spi_resetn),
      .trigger       (trigger),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .status        (status),
      .ready         (ready)
   );

   always #10 aclk = ~aclk;

   function automatic logic [3:0] lanes(input logic [31:0] p);
      return {p[28], p[29], p[30], p[31]};
   endfunction

   // ADC: first lane group valid from csn fall
   always @(negedge spi_csn) begin
      model_shift = adc_pattern;
      spi_sdi     = lanes(adc_pattern);
      model_rises = 0;
   end

   always @(posedge spi_csn) last_rises = model_rises;

   // ADC samples sdo on SCK rise, then moves its data lanes on
   always @(posedge spi_clk) begin
      if (spi_csn === 1'b0) begin
         model_cmd = {model_cmd[22:0], spi_sdo};
         model_rises++;
         #1;
         model_shift = model_shift << 4;
         spi_sdi     = lanes(model_shift);
      end
   end

   task automatic wait_tready(output int n);
      n = 0;
      do begin
         @(posedge aclk); #1; n++;
      end while (s_axis_tready !== 1'b1 && n < 300);
   endtask

   task automatic send_cmd(input logic [31:0] d);
      s_axis_tdata  = d;
      s_axis_tvalid = 1'b1;
      @(posedge aclk); #1;
      s_axis_tvalid = 1'b0;
   endtask

   task automatic fire_trigger();
      trigger = 1'b1;
      fork
         begin #30; trigger = 1'b0; end
      join_none
   endtask

   task automatic test_reset();
      repeat (3) @(posedge aclk); #1;
      total += 9;
      if (spi_csn !== 1'b1)       begin bad++; $display("FAIL rst_csn: got %b want 1", spi_csn); end
      if (spi_clk !== 1'b0)       begin bad++; $display("FAIL rst_clk: got %b want 0", spi_clk); end
      if (spi_sdo !== 1'b0)       begin bad++; $display("FAIL rst_sdo: got %b want 0", spi_sdo); end
      if (spi_resetn !== 1'b0)    begin bad++; $display("FAIL rst_adc_resetn: got %b want 0", spi_resetn); end
      if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL rst_s_tready: got %b want 0", s_axis_tready); end
      if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_m_tvalid: got %b want 0", m_axis_tvalid); end
      if (m_axis_tdata !== 32'h0) begin bad++; $display("FAIL rst_m_tdata: got %h want 0", m_axis_tdata); end
      if (status !== 32'h0)       begin bad++; $display("FAIL rst_status: got %h want 0", status); end
      if (ready !== 1'b0)         begin bad++; $display("FAIL rst_ready: got %b want 0", ready); end
      @(negedge aclk);
      aresetn = 1'b0;
      @(posedge aclk); #1;
      total += 4;
      if (ready !== 1'b1)         begin bad++; $display("FAIL post_rst_ready: got %b want 1", ready); end
      if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL post_rst_s_tready: got %b want 1", s_axis_tready); end
      if (spi_resetn !== 1'b1)    begin bad++; $display("FAIL post_rst_adc_resetn: got %b want 1", spi_resetn); end
      if (status !== 32'h0)       begin bad++; $display("FAIL post_rst_status: got %h want 0", status); end
   endtask

   task automatic test_write_single();
      int n;
      send_cmd(32'h00A00000);
      // Just after the accept edge: csn low with bit 23 (=1) on sdo, state WRITE
      total += 3;
      if (spi_csn !== 1'b0)     begin bad++; $display("FAIL wr_csn_low: got %b want 0", spi_csn); end
      if (spi_sdo !== 1'b1)     begin bad++; $display("FAIL wr_sdo_msb: got %b want 1", spi_sdo); end
      if (status[1:0] !== 2'd1) begin bad++; $display("FAIL wr_state: got %0d want 1", status[1:0]); end
      wait_tready(n);
      // 1 csn-low + 48 SCK half periods + 1 csn-high + 2 GAP = 52 edges
      total += 3;
      if (n != 52)               begin bad++; $display("FAIL wr_duration: got %0d want 52", n); end
      if (last_rises != 24)      begin bad++; $display("FAIL wr_sck_periods: got %0d want 24", last_rises); end
      if (model_cmd !== 24'hA00000) begin bad++; $display("FAIL wr_cmd: got %h want a00000", model_cmd); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] cmds [3] = '{32'h00002080, 32'hFF001501, 32'h00001401};
      logic [23:0] exps [3] = '{24'h002080, 24'h001501, 24'h001401};
      int n;
      for (int i = 0; i < 3; i++) begin
         send_cmd(cmds[i]);
         wait_tready(n);
         total += 2;
         if (n != 52) begin bad++; $display("FAIL b2b_duration[%0d]: got %0d want 52", i, n); end
         if (model_cmd !== exps[i]) begin bad++; $display("FAIL b2b_cmd[%0d]: got %h want %h", i, model_cmd, exps[i]); end
      end
   endtask

   task automatic test_read(input logic [31:0] pattern);
      int n;
      adc_pattern   = pattern;
      m_axis_tready = 1'b1;
      fire_trigger();
      n = 0;
      do begin
         @(posedge aclk); #1; n++;
      end while (m_axis_tvalid !== 1'b1 && n < 100);
      reads_done++;
      // 2 sync edges + 1 detect edge + 1 csn-low + 16 SCK half periods = 20
      total += 4;
      if (n != 20)                begin bad++; $display("FAIL rd_latency: got %0d want 20", n); end
      if (m_axis_tdata !== pattern) begin bad++; $display("FAIL rd_data: got %h want %h", m_axis_tdata, pattern); end
      if (spi_csn !== 1'b1)       begin bad++; $display("FAIL rd_csn_high: got %b want 1", spi_csn); end
      if (status[2:0] !== 3'b110) begin bad++; $display("FAIL rd_status: got %b want 110", status[2:0]); end
      @(posedge aclk); #1;
      total += 1;
      if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rd_tvalid_clear: got %b want 0", m_axis_tvalid); end
      wait_tready(n);
      // tvalid+1 edge: GAP, then 2 GAP cycles -> IDLE; counted from the clear sample
      total += 1;
      if (n != 2) begin bad++; $display("FAIL rd_gap: got %0d want 2", n); end
   endtask

   task automatic test_overflow();
      int n;
      m_axis_tready = 1'b0;
      adc_pattern   = 32'h11111111;
      fire_trigger();
      repeat (25) @(posedge aclk); #1;
      reads_done++;
      total += 2;
      if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL ovf_first_valid: got %b want 1", m_axis_tvalid); end
      if (status[3] !== 1'b0)     begin bad++; $display("FAIL ovf_not_yet: got %b want 0", status[3]); end
      adc_pattern = 32'h2468ACE0;
      fire_trigger();
      repeat (25) @(posedge aclk); #1;
      reads_done++;
      total += 3;
      if (status[3] !== 1'b1)          begin bad++; $display("FAIL ovf_flag: got %b want 1", status[3]); end
      if (m_axis_tdata !== 32'h2468ACE0) begin bad++; $display("FAIL ovf_data: got %h want 2468ace0", m_axis_tdata); end
      if (m_axis_tvalid !== 1'b1)      begin bad++; $display("FAIL ovf_valid: got %b want 1", m_axis_tvalid); end
      m_axis_tready = 1'b1;
      @(posedge aclk); #1;
      total += 2;
      if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL ovf_drain: got %b want 0", m_axis_tvalid); end
      if (status[3] !== 1'b1)     begin bad++; $display("FAIL ovf_sticky: got %b want 1", status[3]); end
      wait_tready(n);
   endtask

   task automatic test_missed();
      int n;
      total += 1;
      if (status[4] !== 1'b0) begin bad++; $display("FAIL miss_clear: got %b want 0", status[4]); end
      send_cmd(32'h00123456);
      repeat (5) @(posedge aclk); #1;
      fire_trigger();
      wait_tready(n);
      total += 4;
      if (status[4] !== 1'b1)       begin bad++; $display("FAIL miss_flag: got %b want 1", status[4]); end
      if (model_cmd !== 24'h123456) begin bad++; $display("FAIL miss_cmd: got %h want 123456", model_cmd); end
      if (m_axis_tvalid !== 1'b0)   begin bad++; $display("FAIL miss_no_sample: got %b want 0", m_axis_tvalid); end
      if (n != 47)                  begin bad++; $display("FAIL miss_duration: got %0d want 47", n); end
   endtask

   task automatic test_counter();
      logic [15:0] exp_cnt;
`ifdef ADC_MANAGER_CNV_COUNTER_EN
      exp_cnt = 16'(reads_done);
`else
      exp_cnt = 16'h0;
`endif
      total += 1;
      if (status[31:16] !== exp_cnt) begin bad++; $display("FAIL cnv_count: got %0d want %0d", status[31:16], exp_cnt); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_write_single();
      test_back_to_back();
      test_read(32'h8BADF00D);
      test_read(32'h0023FF42);
      test_overflow();
      test_missed();
      test_counter();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
